// File: rtl/gpr_write_arbiter_pkg.sv
// Shared GPR widths, enable levels and write-arbiter types.
// The long-latency FIFO depth and starvation counter width live next to the register-bus widths.
package gpr_write_arbiter_pkg;

    localparam int   REGS_ADDR_W      = 5;
    localparam int   REGS_DATA_W      = 32;
    localparam int   REGS_NUM         = 32;
    localparam logic ENABLE           = 1'b1;
    localparam logic DISABLE          = 1'b0;
    localparam int   LR_FIFO_DEPTH    = 2;
    localparam int   STARVE_CNT_WIDTH = 4;

    typedef logic [REGS_ADDR_W-1:0]      reg_addr_t;
    typedef logic [REGS_DATA_W-1:0]      reg_data_t;
    typedef logic [1:0]                  fifo_cnt_t;
    typedef logic [STARVE_CNT_WIDTH-1:0] starve_cnt_t;

    typedef struct packed {
        reg_addr_t waddr;
        reg_data_t wdata;
    } lr_entry_t;

    // Which source drives the GPR write port in the current cycle.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_WB   = 2'd1,
        OWNER_LR   = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e      owner;
        fifo_cnt_t   count;
        starve_cnt_t starve_cnt;
        logic        wb_stall;
    } arb_dbg_t;

endpackage

// File: rtl/gpr_write_arbiter_if.sv
// Signal bundle between the pipeline/long-latency unit (master) and the GPR write arbiter (slave).
// Handshake: a long-latency result transfers on a clock edge where lr_valid && lr_ready; lr_ready never depends on lr_valid.
interface gpr_write_arbiter_if;
    import gpr_write_arbiter_pkg::*;

    logic      wb_write_enable;
    reg_addr_t wb_waddr;
    reg_data_t wb_wdata;

    logic      lr_valid;
    logic      lr_ready;
    reg_addr_t lr_waddr;
    reg_data_t lr_wdata;

    logic      issue_enable;
    reg_addr_t issue_waddr;

    reg_addr_t query_addr1;
    reg_addr_t query_addr2;
    logic      query_busy1;
    logic      query_busy2;

    logic      gpr_write_enable;
    reg_addr_t gpr_waddr;
    reg_data_t gpr_wdata;

    logic      wb_stall;
    arb_dbg_t  dbg;

    modport master (
        output wb_write_enable, wb_waddr, wb_wdata,
        output lr_valid, lr_waddr, lr_wdata,
        output issue_enable, issue_waddr,
        output query_addr1, query_addr2,
        input  lr_ready, query_busy1, query_busy2,
        input  gpr_write_enable, gpr_waddr, gpr_wdata,
        input  wb_stall, dbg
    );

    modport slave (
        input  wb_write_enable, wb_waddr, wb_wdata,
        input  lr_valid, lr_waddr, lr_wdata,
        input  issue_enable, issue_waddr,
        input  query_addr1, query_addr2,
        output lr_ready, query_busy1, query_busy2,
        output gpr_write_enable, gpr_waddr, gpr_wdata,
        output wb_stall, dbg
    );

endinterface

// File: rtl/gpr_write_arbiter_scoreboard.sv
// Per-GPR pending bits for outstanding long-latency writes, with two decode query ports.
// A set and a clear to the same register in one cycle leaves the bit set (the newer issue wins).
module gpr_scoreboard
    import gpr_write_arbiter_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      set_enable,
    input  reg_addr_t set_addr,
    input  logic      clear_enable,
    input  reg_addr_t clear_addr,
    input  reg_addr_t query_addr1,
    input  reg_addr_t query_addr2,
    output logic      query_busy1,
    output logic      query_busy2
);

    logic [REGS_NUM-1:0] pending;
    logic [REGS_NUM-1:0] pending_next;

    always_comb begin
        pending_next = pending;
        if (clear_enable == ENABLE) begin
            pending_next[clear_addr] = 1'b0;
        end
        if (set_enable == ENABLE) begin
            pending_next[set_addr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset == ENABLE) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Bit 0 is never set, so address 0 always reads as not busy.
    always_comb begin
        query_busy1 = 1'b0;
        query_busy2 = 1'b0;
        if (reset == DISABLE) begin
            query_busy1 = pending[query_addr1];
            query_busy2 = pending[query_addr2];
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Single GPR write port shared by pipeline writeback (always wins) and a 2-entry long-latency result FIFO.
// Raises wb_stall when the FIFO has been blocked for STARVE_LIMIT cycles so the pipeline leaves a slot free.
module gpr_write_arbiter
    import gpr_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic                clock,
    input logic                reset,
    gpr_write_arbiter_if.slave bus
);

    localparam starve_cnt_t STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);
    localparam fifo_cnt_t   FIFO_FULL  = 2'(LR_FIFO_DEPTH);

    lr_entry_t   fifo_mem [LR_FIFO_DEPTH];
    logic        rd_ptr;
    logic        wr_ptr;
    fifo_cnt_t   count;
    starve_cnt_t starve_cnt;
    logic        wb_stall_q;

    logic      wb_owns;
    logic      push;
    logic      drain;
    lr_entry_t head;
    owner_e    owner;

    always_comb begin
        wb_owns      = (bus.wb_write_enable == ENABLE) && (bus.wb_waddr != '0);
        bus.lr_ready = (count != FIFO_FULL) && (reset == DISABLE);
        // Results aimed at $0 complete the handshake but are dropped here.
        push         = bus.lr_valid && bus.lr_ready && (bus.lr_waddr != '0);
        head         = fifo_mem[rd_ptr];
    end

    always_comb begin
        owner                = OWNER_NONE;
        bus.gpr_write_enable = DISABLE;
        bus.gpr_waddr        = '0;
        bus.gpr_wdata        = '0;
        if (reset == DISABLE) begin
            if (wb_owns) begin
                owner                = OWNER_WB;
                bus.gpr_write_enable = ENABLE;
                bus.gpr_waddr        = bus.wb_waddr;
                bus.gpr_wdata        = bus.wb_wdata;
            end else if (count != '0) begin
                owner                = OWNER_LR;
                bus.gpr_write_enable = ENABLE;
                bus.gpr_waddr        = head.waddr;
                bus.gpr_wdata        = head.wdata;
            end
        end
        drain = (owner == OWNER_LR);
    end

    // Storage carries no reset; count and pointers alone say which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{waddr: bus.lr_waddr, wdata: bus.lr_wdata};
        end
    end

    always_ff @(posedge clock) begin
        if (reset == ENABLE) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + fifo_cnt_t'(push) - fifo_cnt_t'(drain);
        end
    end

    // The stall is held from the cycle after saturation until the cycle after the next drain.
    always_ff @(posedge clock) begin
        if (reset == ENABLE) begin
            starve_cnt <= '0;
            wb_stall_q <= 1'b0;
        end else begin
            if (drain || (count == '0)) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            wb_stall_q <= !drain && (wb_stall_q || (starve_cnt == STARVE_MAX));
        end
    end

    always_comb begin
        bus.wb_stall       = wb_stall_q;
        bus.dbg.owner      = owner;
        bus.dbg.count      = count;
        bus.dbg.starve_cnt = starve_cnt;
        bus.dbg.wb_stall   = wb_stall_q;
    end

    gpr_scoreboard u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .set_enable   (bus.issue_enable),
        .set_addr     (bus.issue_waddr),
        .clear_enable (drain),
        .clear_addr   (head.waddr),
        .query_addr1  (bus.query_addr1),
        .query_addr2  (bus.query_addr2),
        .query_busy1  (bus.query_busy1),
        .query_busy2  (bus.query_busy2)
    );

endmodule

// File: doc/gpr_write_arbiter.md
# gpr_write_arbiter

Shares the single write port of the GPR file between the in-order pipeline writeback and a long-latency result source (divider / future cache-miss loads). Pipeline writeback always wins; long-latency results wait in a 2-entry FIFO and drain on idle write-port cycles. A per-register pending scoreboard tells the decode stage which GPRs still have an outstanding long-latency write, and a starvation counter requests a pipeline bubble when the FIFO cannot drain.

## Interface
- STARVE_LIMIT, 4: consecutive blocked cycles with a non-empty FIFO before `wb_stall` is raised; legal range 1..15.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high (`ENABLE`).
- wb_write_enable  in  1  pipeline writeback request.
- wb_waddr  in  `REGS_ADDR_BUS`  pipeline destination.
- wb_wdata  in  `REGS_DATA_BUS`  pipeline data.
- lr_valid  in  1  long-latency result offered.
- lr_ready  out  1  FIFO can accept; transfer when `lr_valid && lr_ready`.
- lr_waddr  in  `REGS_ADDR_BUS`  long-latency destination.
- lr_wdata  in  `REGS_DATA_BUS`  long-latency data.
- issue_enable  in  1  a long-latency op dispatched this cycle.
- issue_waddr  in  `REGS_ADDR_BUS`  its destination.
- query_addr1, query_addr2  in  `REGS_ADDR_BUS`  decode source operands.
- query_busy1, query_busy2  out  1  operand has a pending long-latency write (combinational).
- gpr_write_enable, gpr_waddr, gpr_wdata  out  1 / addr / data  to the GPR file write port (combinational).
- wb_stall  out  1  registered; asks pipeline to leave the next writeback slot empty.

## Operation
- Port owner: pipeline owns the port when `wb_write_enable == ENABLE && wb_waddr != 0`; then `gpr_* = wb_*`. Otherwise, if the FIFO is non-empty, the head drains: `gpr_write_enable = ENABLE`, `gpr_* = head`, pop. Otherwise `gpr_write_enable = DISABLE`, addr/data 0.
- FIFO: depth 2, occupancy `count` 0..2; `lr_ready = (count != 2) && reset == DISABLE`. Push on handshake; an accepted result with `lr_waddr == 0` is discarded, not pushed. Push and pop in the same cycle at count 1 leaves count 1 and preserves order. No push-to-port bypass: minimum lr-to-GPR latency is 1 cycle.
- Scoreboard: `pending[1..31]`, bit 0 hardwired 0. `issue_enable` sets `pending[issue_waddr]` (addr 0 ignored). A drain clears `pending[head.waddr]`. Issue and drain to the same address in one cycle: set wins.
- `query_busyN = pending[query_addrN]`; address 0 always 0. Pending covers results still inside the divider and results queued in the FIFO.
- Starvation: 4-bit `starve_cnt` increments each cycle with count != 0 and no drain, saturating at STARVE_LIMIT; it clears on any drain or when the FIFO is empty. `wb_stall` is registered high the cycle after `starve_cnt` reaches STARVE_LIMIT. It stays high until the cycle after a drain. A pipeline write while `wb_stall` is high still wins; no data is ever dropped.
- WAW between a pipeline write and a pending register is prevented upstream by decode stalling on `query_busy`; this block does not check it.

## Timing
- Reset (sync): count = 0, FIFO contents invalid, pending = 0, starve_cnt = 0, wb_stall = 0. During the reset cycle: `lr_ready = 0`, `gpr_write_enable = DISABLE`, query_busy = 0.
- Reset mid-operation discards queued results and pending bits. The long-latency unit is reset by the same signal.
- Pipeline writeback: 0-cycle pass-through. Long-latency write: at least 1 cycle after acceptance, unbounded under contention, bounded by the STARVE_LIMIT + 2 cycles after the pipeline honours `wb_stall`.
- `lr_ready` depends only on registered count. It is never combinational from `lr_valid`.

## Structure
- Add `LR_FIFO_DEPTH` (2) and `STARVE_CNT_WIDTH` (4) to the shared utility header, next to the existing `REGS_*`, `ENABLE` and `DISABLE` macros.
- Natural sub-module: `gpr_scoreboard` (pending bits, set/clear priority, two query ports). The FIFO and arbitration stay inline.

## Test plan
- Reset, then idle: `lr_ready = 1`, `gpr_write_enable = 0`, `wb_stall = 0`, `query_busy1` for $5 = 0.
- Issue $8, then lr result ($8, 0xDEADBEEF) with wb idle: `query_busy` for $8 = 1 until the drain cycle. The GPR write ($8, 0xDEADBEEF) happens 1 cycle after acceptance; busy = 0 the next cycle.
- wb writes every cycle, and two lr results ($3 = 0x11, $4 = 0x22) are offered: both are accepted, then `lr_ready = 0`. `wb_stall` rises after 4 blocked cycles. Drop wb for 2 cycles: $3 is written, then $4, and wb_stall falls.
- Push and pop at count 1: order preserved and count stays 1. An lr result to $0 is accepted and never reaches the port.
- Issue $9 and drain an older $9 result in the same cycle: `pending[9]` stays 1.
- Assert reset with count = 2 and pending $3/$4 set: after reset, count = 0, no writes are issued, and both busy bits = 0.
